// File: rtl/selection_join_buffer_pkg.sv
// Shared helpers for the selection join buffer.
// Contents:
//   clog2       - ceiling log2 constant function, usable in port widths.
//   ptr_width   - read/write pointer width for a FIFO of the given depth (at least 1 bit).
//   count_width - occupancy counter width; one extra bit so a full FIFO is representable.
package selection_join_buffer_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/selection_join_buffer_fifo.sv
// tagged_vector_fifo: in-order store of {tag, vector} entries waiting for their
// selection-test indicator.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (pointers/count only)
//   push, wr_data    write wr_data at the tail (caller guarantees ~full)
//   pop              retire the head entry (caller guarantees ~empty)
//   head             current head entry, combinational read
//   count            entries currently stored
//   full, empty      occupancy flags
module tagged_vector_fifo
    import selection_join_buffer_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      head,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Storage carries no reset: stale contents are unreachable once pointers clear.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/selection_join_buffer.sv
// selection_join_buffer: holds tagged data vectors in order until the centered
// selection test delivers the matching 1-bit indicator, then presents
// {vector, indicator, tag} to the projection stage behind valid/ready.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   vec_valid_in/vec_tag_in/vec_data_in upstream vector; vec_ready_out = not full
//   ind_valid_in/ind_tag_in/ind_in      selection-test result; ind_ready_out = join possible
//   ready_in                            downstream ready
//   valid_out/tag_out/data_out/indicator_out  joined result, held while stalled
//   count                               entries buffered
//   busy                                entries buffered or result pending
//   tag_error                           sticky: an indicator tag differed from the head tag
module selection_join_buffer
    import selection_join_buffer_pkg::*;
#(
    parameter int TAG_WIDTH      = 32,
    parameter int BLOCKLENGTH    = 1,
    parameter int DATA_WIDTH     = 8,
    parameter int FRACTION_WIDTH = 6,
    parameter int DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vec_valid_in,
    input  logic [TAG_WIDTH-1:0]              vec_tag_in,
    input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] vec_data_in,
    output logic                              vec_ready_out,
    input  logic                              ind_valid_in,
    input  logic [TAG_WIDTH-1:0]              ind_tag_in,
    input  logic                              ind_in,
    output logic                              ind_ready_out,
    input  logic                              ready_in,
    output logic                              valid_out,
    output logic [TAG_WIDTH-1:0]              tag_out,
    output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
    output logic                              indicator_out,
    output logic [clog2(DEPTH):0]             count,
    output logic                              busy,
    output logic                              tag_error
);

    localparam int VEC_W   = DATA_WIDTH * BLOCKLENGTH;
    localparam int ENTRY_W = TAG_WIDTH + VEC_W;

    // Elaboration-time sanity checks on the configuration.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("selection_join_buffer: DEPTH must be a power of two >= 2");
        end
        if ((FRACTION_WIDTH < 0) || (FRACTION_WIDTH > DATA_WIDTH) || (BLOCKLENGTH < 1)) begin : g_bad_format
            $error("selection_join_buffer: invalid element format");
        end
    endgenerate

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   head;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [VEC_W-1:0]     head_data;

    logic                 valid_reg;
    logic [TAG_WIDTH-1:0] tag_reg;
    logic [VEC_W-1:0]     data_reg;
    logic                 indicator_reg;
    logic                 tag_error_reg;

    tagged_vector_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({vec_tag_in, vec_data_in}),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_tag  = head[ENTRY_W-1 -: TAG_WIDTH];
    assign head_data = head[VEC_W-1:0];

    // Full blocks a push even when a pop frees a slot in the same cycle; this
    // keeps vec_ready_out independent of the indicator/downstream handshakes.
    assign vec_ready_out = ~fifo_full;
    assign fifo_push     = vec_valid_in & vec_ready_out;

    // A join needs a head entry and a free (or freeing) output register.
    assign ind_ready_out = ~fifo_empty & (~valid_reg | ready_in);
    assign fifo_pop      = ind_valid_in & ind_ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            tag_reg       <= '0;
            data_reg      <= '0;
            indicator_reg <= 1'b0;
            tag_error_reg <= 1'b0;
        end else begin
            if (fifo_pop) begin
                valid_reg     <= 1'b1;
                tag_reg       <= head_tag;
                data_reg      <= head_data;
                indicator_reg <= ind_in;
            end else if (ready_in) begin
                valid_reg <= 1'b0;
            end
            // A mismatched tag still joins with the head entry; the flag only records it.
            if (fifo_pop && (ind_tag_in != head_tag)) begin
                tag_error_reg <= 1'b1;
            end
        end
    end

    assign valid_out     = valid_reg;
    assign tag_out       = tag_reg;
    assign data_out      = data_reg;
    assign indicator_out = indicator_reg;
    assign tag_error     = tag_error_reg;
    assign busy          = ~fifo_empty | valid_reg;

endmodule

// File: tb/tb_selection_join_buffer.sv
// Directed bench for selection_join_buffer (BLOCKLENGTH=2, DATA_WIDTH=8, DEPTH=4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_selection_join_buffer;

    localparam int TW    = 32;
    localparam int BL    = 2;
    localparam int DW    = 8;
    localparam int FW    = 6;
    localparam int DEPTH = 4;
    localparam int VW    = DW * BL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vec_valid_in = 1'b0;
    logic [TW-1:0] vec_tag_in = '0;
    logic [VW-1:0] vec_data_in = '0;
    logic          vec_ready_out;
    logic          ind_valid_in = 1'b0;
    logic [TW-1:0] ind_tag_in = '0;
    logic          ind_in = 1'b0;
    logic          ind_ready_out;
    logic          ready_in = 1'b0;
    logic          valid_out;
    logic [TW-1:0] tag_out;
    logic [VW-1:0] data_out;
    logic          indicator_out;
    logic [2:0]    count;
    logic          busy;
    logic          tag_error;

    selection_join_buffer #(
        .TAG_WIDTH      (TW),
        .BLOCKLENGTH    (BL),
        .DATA_WIDTH     (DW),
        .FRACTION_WIDTH (FW),
        .DEPTH          (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vec_valid_in  (vec_valid_in),
        .vec_tag_in    (vec_tag_in),
        .vec_data_in   (vec_data_in),
        .vec_ready_out (vec_ready_out),
        .ind_valid_in  (ind_valid_in),
        .ind_tag_in    (ind_tag_in),
        .ind_in        (ind_in),
        .ind_ready_out (ind_ready_out),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .tag_out       (tag_out),
        .data_out      (data_out),
        .indicator_out (indicator_out),
        .count         (count),
        .busy          (busy),
        .tag_error     (tag_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] data;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] data;
        logic          ind;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];      // model of buffered vectors
    res_t sb[$];      // scoreboard of joined results awaiting output
    logic m_valid = 1'b0;
    logic m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic vv, input logic [TW-1:0] vtag, input logic [VW-1:0] vdata,
                        input logic iv, input logic [TW-1:0] itag, input logic ii, input logic rdy);
        logic m_push;
        logic m_pop;
        logic ind_rdy;
        vec_t h;
        res_t r;
        vec_valid_in = vv;
        vec_tag_in   = vtag;
        vec_data_in  = vdata;
        ind_valid_in = iv;
        ind_tag_in   = itag;
        ind_in       = ii;
        ready_in     = rdy;
        #1;
        ind_rdy = (vq.size() != 0) && (!m_valid || rdy);
        chk("vec_ready", 64'(vec_ready_out), 64'(vq.size() != DEPTH));
        chk("ind_ready", 64'(ind_ready_out), 64'(ind_rdy));
        chk("count", 64'(count), 64'(vq.size()));
        chk("busy", 64'(busy), 64'((vq.size() != 0) || m_valid));
        chk("tag_error", 64'(tag_error), 64'(m_err));
        chk("valid_out", 64'(valid_out), 64'(m_valid));
        if (m_valid && sb.size() > 0) begin
            r = sb[0];
            chk("data_out", 64'(data_out), 64'(r.data));
            chk("tag_out", 64'(tag_out), 64'(r.tag));
            chk("indicator_out", 64'(indicator_out), 64'(r.ind));
            if (rdy) begin
                void'(sb.pop_front());
                $display("out tag=%0d data=%h ind=%0b", tag_out, data_out, indicator_out);
            end
        end
        m_push = vv && (vq.size() != DEPTH);
        m_pop  = iv && ind_rdy;
        if (m_pop) begin
            h = vq.pop_front();
            if (itag != h.tag) m_err = 1'b1;
            sb.push_back('{h.tag, h.data, ii});
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (m_push) vq.push_back('{vtag, vdata});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [TW-1:0] t, input logic [VW-1:0] d);
        step(1'b1, t, d, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic join_ind(input logic [TW-1:0] t, input logic i, input logic rdy);
        step(1'b0, '0, '0, 1'b1, t, i, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        vec_valid_in = 1'b0;
        ind_valid_in = 1'b0;
        ready_in     = 1'b0;
        reset        = 1'b1;
        #1;
        vq.delete();
        sb.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        chk("rst_valid_out", 64'(valid_out), 64'(0));
        chk("rst_tag_out", 64'(tag_out), 64'(0));
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_indicator_out", 64'(indicator_out), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tag_error", 64'(tag_error), 64'(0));
        chk("rst_vec_ready", 64'(vec_ready_out), 64'(1));
        chk("rst_ind_ready", 64'(ind_ready_out), 64'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single push then join: one-cycle join latency.
        push(32'd5, 16'hC040);
        join_ind(32'd5, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill to DEPTH, fifth push held, join frees a slot the cycle after.
        for (int i = 0; i < 4; i++) push(32'(10 + i), 16'(16'hA000 + i));
        push(32'd14, 16'h2222);
        step(1'b1, 32'd14, 16'h2222, 1'b1, 32'd10, 1'b1, 1'b1);
        push(32'd14, 16'h2222);
        for (int t = 11; t <= 14; t++) join_ind(32'(t), t[0], 1'b1);
        idle(1'b1);

        // Output stall with two entries left, then back-to-back streaming.
        push(32'd20, 16'h1414);
        push(32'd21, 16'h1515);
        push(32'd22, 16'h1616);
        join_ind(32'd20, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) join_ind(32'd21, 1'b0, 1'b0);
        join_ind(32'd21, 1'b0, 1'b1);
        join_ind(32'd22, 1'b1, 1'b1);
        idle(1'b1);

        // Tag mismatch: joins with head data/tag, sticky error.
        push(32'd3, 16'h0303);
        join_ind(32'd4, 1'b0, 1'b1);
        push(32'd7, 16'h0707);
        join_ind(32'd7, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stream with entries buffered, then fresh traffic.
        push(32'd30, 16'h3030);
        push(32'd31, 16'h3131);
        push(32'd32, 16'h3232);
        do_reset();
        push(32'd9, 16'h0909);
        join_ind(32'd9, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        chk("model_fifo_drained", 64'(vq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
